// File: rtl/azadi_spi_pkg.sv
// Shared types and constants for the azadi SPI responder.
package azadi_spi_pkg;

   // {CPOL, CPHA}
   typedef logic [1:0] spi_mode_t;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_e;

   // Synchroniser reset values: deselected bus, MOSI low.
   localparam logic SS_SYNC_RST   = 1'b1;
   localparam logic MOSI_SYNC_RST = 1'b0;

   // SCLK rests at its idle level, which is CPOL.
   function automatic logic sclk_sync_rst(spi_mode_t mode);
      return mode[1];
   endfunction

   // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
   function automatic logic sample_on_rise(spi_mode_t mode);
      return mode[1] == mode[0];
   endfunction

endpackage

// File: rtl/azadi_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous pin.
module azadi_sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic sync_p0;

   // First flop may go metastable; second flop gives it a cycle to settle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_p0 <= RST_VAL;
         q_o     <= RST_VAL;
      end else begin
         sync_p0 <= d_i;
         q_o     <= sync_p0;
      end
   end

endmodule

// File: rtl/azadi_spi_responder.sv
// SPI responder: oversampled pins, full-duplex DATA_W-bit words, one-entry TX holding register.
module azadi_spi_responder
   import azadi_spi_pkg::*;
#(
   parameter int                DATA_W     = 8,
   parameter logic              CPOL       = 1'b0,
   parameter logic              CPHA       = 1'b0,
   parameter logic [DATA_W-1:0] DEFAULT_TX = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              sclk_i,
   input  logic              ss_ni,
   input  logic              mosi_i,
   output logic              miso_o,
   output logic              miso_oe_o,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic              tx_valid_i,
   output logic              tx_ready_o,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              rx_valid_o,
   output logic              tx_underrun_o,
   output logic              abort_o
);

   localparam spi_mode_t       MODE     = {CPOL, CPHA};
   localparam int              CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   logic sclk_p1, ss_p1, mosi_p1;
   logic sclk_p2, ss_p2;

   spi_state_e state, state_n;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] tx_shift;
   logic [DATA_W-1:0] hold_data;
   logic              hold_full;
   logic [DATA_W-2:0] rx_shift;
   logic [DATA_W-1:0] rx_word;

   logic sclk_rise, sclk_fall, sample_edge, shift_edge, ss_fall, ss_rise;
   logic load, shift, sample, word_end, abort_n, wr;

   azadi_sync_2ff #(.RST_VAL(sclk_sync_rst(MODE))) u_sync_sclk (
      .clk_i (clk_i), .rst_i (rst_i), .d_i (sclk_i), .q_o (sclk_p1));
   azadi_sync_2ff #(.RST_VAL(SS_SYNC_RST)) u_sync_ss (
      .clk_i (clk_i), .rst_i (rst_i), .d_i (ss_ni), .q_o (ss_p1));
   azadi_sync_2ff #(.RST_VAL(MOSI_SYNC_RST)) u_sync_mosi (
      .clk_i (clk_i), .rst_i (rst_i), .d_i (mosi_i), .q_o (mosi_p1));

   // Delayed copies of synced SCLK and SS_N for edge detection.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sclk_p2 <= sclk_sync_rst(MODE);
         ss_p2   <= SS_SYNC_RST;
      end else begin
         sclk_p2 <= sclk_p1;
         ss_p2   <= ss_p1;
      end
   end

   assign sclk_rise   = sclk_p1 & ~sclk_p2;
   assign sclk_fall   = ~sclk_p1 & sclk_p2;
   assign sample_edge = sample_on_rise(MODE) ? sclk_rise : sclk_fall;
   assign shift_edge  = sample_on_rise(MODE) ? sclk_fall : sclk_rise;
   assign ss_fall     = ss_p2 & ~ss_p1;
   assign ss_rise     = ~ss_p2 & ss_p1;
   assign rx_word     = {rx_shift, mosi_p1};
   assign wr          = tx_valid_i & ~hold_full;

   // FSM state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_n;
   end

   // Next state and per-cycle actions; a sample is still taken on the cycle SS_N rises.
   always_comb begin
      state_n  = state;
      load     = 1'b0;
      shift    = 1'b0;
      sample   = 1'b0;
      word_end = 1'b0;
      abort_n  = 1'b0;
      case (state)
         IDLE: begin
            if (ss_fall) begin
               state_n = ACTIVE;
               load    = ~CPHA;
            end
         end
         ACTIVE: begin
            sample   = sample_edge;
            word_end = sample_edge && (bit_cnt == LAST_BIT);
            if (ss_rise) begin
               state_n = IDLE;
               abort_n = ~word_end && ((bit_cnt != '0) || sample_edge);
            end else if (shift_edge) begin
               // A shift edge at bit 0 starts a new word instead of shifting.
               if (bit_cnt == '0) load  = 1'b1;
               else               shift = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Bit counter, holding-register flag, RX word and status pulses.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bit_cnt       <= '0;
         hold_full     <= 1'b0;
         rx_data_o     <= '0;
         rx_valid_o    <= 1'b0;
         tx_underrun_o <= 1'b0;
         abort_o       <= 1'b0;
      end else begin
         if (state_n == IDLE) bit_cnt <= '0;
         else if (sample)     bit_cnt <= word_end ? '0 : bit_cnt + 1'b1;
         if (load) hold_full <= 1'b0;
         if (wr)   hold_full <= 1'b1;
         if (word_end) rx_data_o <= rx_word;
         rx_valid_o    <= word_end;
         tx_underrun_o <= load & ~hold_full;
         abort_o       <= abort_n;
      end
   end

   // Datapath shifters and holding register; validity is tracked by the control flags.
   always_ff @(posedge clk_i) begin
      if (wr) hold_data <= tx_data_i;
      if (load)       tx_shift <= hold_full ? hold_data : DEFAULT_TX;
      else if (shift) tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      if (sample) rx_shift <= rx_word[DATA_W-2:0];
   end

   assign tx_ready_o = ~hold_full;
   assign miso_oe_o  = (state == ACTIVE);
   assign miso_o     = (state == ACTIVE) & tx_shift[DATA_W-1];

endmodule

// File: tb/tb_azadi_spi_responder.sv
// Bench for azadi_spi_responder: one instance per SPI mode, driven by a bit-level host model.
module tb_azadi_spi_responder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] sclk, ss_n, miso, oe, tx_ready, rx_valid, und, abrt;
   logic       mosi;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic [7:0] rx_data [4];
   int         sel = 0;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] tx_q [$];
   logic [7:0] rx_got [$];
   int         und_cnt = 0;
   int         ab_cnt  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      azadi_spi_responder #(
         .DATA_W (8), .CPOL (1'(g / 2)), .CPHA (1'(g % 2)), .DEFAULT_TX (8'h00)
      ) u_dut (
         .clk_i         (clk),
         .rst_i         (rst),
         .sclk_i        (sclk[g]),
         .ss_ni         (ss_n[g]),
         .mosi_i        (mosi),
         .miso_o        (miso[g]),
         .miso_oe_o     (oe[g]),
         .tx_data_i     (tx_data),
         .tx_valid_i    (tx_valid && (sel == g)),
         .tx_ready_o    (tx_ready[g]),
         .rx_data_o     (rx_data[g]),
         .rx_valid_o    (rx_valid[g]),
         .tx_underrun_o (und[g]),
         .abort_o       (abrt[g])
      );
   end

   // Local producer: hands queued words to the selected DUT one handshake at a time.
   initial begin
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (tx_valid) begin
            tx_valid = 1'b0;
            void'(tx_q.pop_front());
         end else if (!rst && tx_q.size() > 0 && tx_ready[sel]) begin
            tx_valid = 1'b1;
            tx_data  = tx_q[0];
         end
      end
   end

   // Monitor: records received words and pulse counts of the selected DUT.
   always @(negedge clk) begin
      if (rx_valid[sel]) rx_got.push_back(rx_data[sel]);
      if (und[sel])      und_cnt++;
      if (abrt[sel])     ab_cnt++;
   end

   task automatic hcyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Host: clocks nbits bits MSB first; ends the frame unless keep_low is set.
   task automatic run_frame(input int m, input logic [7:0] words [4], input int nbits,
                            input bit keep_low, output logic [7:0] got [4],
                            output bit oe_ok, output int oe_lat);
      bit cpol, cpha;
      cpol   = m[1];
      cpha   = m[0];
      oe_ok  = 1'b1;
      oe_lat = 0;
      for (int k = 0; k < 4; k++) got[k] = 8'h00;
      if (!cpha) mosi = words[0][7];
      ss_n[m] = 1'b0;
      hcyc(8);
      for (int i = 0; i < nbits; i++) begin
         if (cpha) begin
            sclk[m] = ~cpol;
            mosi    = words[i / 8][7 - (i % 8)];
            hcyc(4);
            sclk[m] = cpol;
            got[i / 8][7 - (i % 8)] = miso[m];
            oe_ok &= oe[m];
            hcyc(4);
         end else begin
            sclk[m] = ~cpol;
            got[i / 8][7 - (i % 8)] = miso[m];
            oe_ok &= oe[m];
            hcyc(4);
            if (i < nbits - 1) begin
               sclk[m] = cpol;
               mosi    = words[(i + 1) / 8][7 - ((i + 1) % 8)];
               hcyc(4);
            end
         end
      end
      if (!keep_low) begin
         ss_n[m] = 1'b1;
         while (oe[m] && oe_lat < 8) begin
            hcyc(1);
            oe_lat++;
         end
         hcyc(2);
         sclk[m] = cpol;
         hcyc(8);
      end
   endtask

   task automatic chk_reset_outputs(input int m, input string tag);
      chk({tag, "_miso"},     32'(miso[m]),     32'h0);
      chk({tag, "_oe"},       32'(oe[m]),       32'h0);
      chk({tag, "_tx_ready"}, 32'(tx_ready[m]), 32'h1);
      chk({tag, "_rx_data"},  32'(rx_data[m]),  32'h0);
      chk({tag, "_rx_valid"}, 32'(rx_valid[m]), 32'h0);
      chk({tag, "_underrun"}, 32'(und[m]),      32'h0);
      chk({tag, "_abort"},    32'(abrt[m]),     32'h0);
   endtask

   initial begin
      logic [7:0] words [4];
      logic [7:0] got [4];
      logic [7:0] txw [4];
      logic [7:0] exp_rx;
      bit         oe_ok;
      int         lat, r0, u0, a0, m, n, k;

      sclk = 4'b1100;
      ss_n = 4'hF;
      mosi = 1'b0;
      for (int i = 0; i < 4; i++) words[i] = 8'h00;
      hcyc(3);
      for (int i = 0; i < 4; i++) chk_reset_outputs(i, "reset");
      rst = 1'b0;
      hcyc(4);

      // Preloaded A5 against host word 3C, in every mode.
      for (int md = 0; md < 4; md++) begin
         sel = md;
         tx_q.push_back(8'hA5);
         hcyc(6);
         r0 = rx_got.size(); u0 = und_cnt; a0 = ab_cnt;
         words[0] = 8'h3C;
         run_frame(md, words, 8, 1'b0, got, oe_ok, lat);
         chk($sformatf("m%0d_miso", md), 32'(got[0]), 32'hA5);
         chk($sformatf("m%0d_rx_cnt", md), 32'(rx_got.size() - r0), 32'd1);
         chk($sformatf("m%0d_rx_word", md), 32'(rx_data[md]), 32'h3C);
         chk($sformatf("m%0d_underrun", md), 32'(und_cnt - u0), 32'd0);
         chk($sformatf("m%0d_abort", md), 32'(ab_cnt - a0), 32'd0);
         chk($sformatf("m%0d_tx_ready", md), 32'(tx_ready[md]), 32'h1);
         chk($sformatf("m%0d_oe_active", md), 32'(oe_ok), 32'h1);
         chk($sformatf("m%0d_oe_idle", md), 32'(oe[md]), 32'h0);
      end

      // Empty holding register: default word goes out, one underrun.
      sel = 0;
      r0 = rx_got.size(); u0 = und_cnt;
      words[0] = 8'hFF;
      run_frame(0, words, 8, 1'b0, got, oe_ok, lat);
      chk("empty_miso", 32'(got[0]), 32'h00);
      chk("empty_underrun", 32'(und_cnt - u0), 32'd1);
      chk("empty_rx", 32'(rx_data[0]), 32'hFF);

      // Three-word frame with refills.
      tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33);
      hcyc(6);
      r0 = rx_got.size(); u0 = und_cnt;
      words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
      run_frame(0, words, 24, 1'b0, got, oe_ok, lat);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("multi_miso%0d", i), 32'(got[i]), 32'(8'h11 * (i + 1)));
         chk($sformatf("multi_rx%0d", i),
             (rx_got.size() > r0 + i) ? 32'(rx_got[r0 + i]) : 32'hFFFF_FFFF, 32'(i + 1));
      end
      chk("multi_rx_cnt", 32'(rx_got.size() - r0), 32'd3);
      chk("multi_underrun", 32'(und_cnt - u0), 32'd0);

      // Abort after 5 bits; the loaded word is not re-sent.
      tx_q.push_back(8'h77);
      hcyc(6);
      r0 = rx_got.size(); a0 = ab_cnt;
      words[0] = 8'hC3;
      run_frame(0, words, 5, 1'b0, got, oe_ok, lat);
      chk("abort_pulse", 32'(ab_cnt - a0), 32'd1);
      chk("abort_no_rx", 32'(rx_got.size() - r0), 32'd0);
      chk("abort_rx_kept", 32'(rx_data[0]), 32'h03);
      chk("abort_oe_lat", 32'(lat <= 4), 32'h1);
      tx_q.push_back(8'h88);
      hcyc(6);
      u0 = und_cnt;
      words[0] = 8'h42;
      run_frame(0, words, 8, 1'b0, got, oe_ok, lat);
      chk("after_abort_miso", 32'(got[0]), 32'h88);
      chk("after_abort_rx", 32'(rx_data[0]), 32'h42);
      chk("after_abort_underrun", 32'(und_cnt - u0), 32'd0);

      // Reset during bit 4, then a clean frame.
      tx_q.push_back(8'h99);
      hcyc(6);
      words[0] = 8'hE7;
      run_frame(0, words, 4, 1'b1, got, oe_ok, lat);
      rst = 1'b1;
      #1;
      chk_reset_outputs(0, "midrst");
      sclk[0] = 1'b0;
      ss_n[0] = 1'b1;
      hcyc(4);
      rst = 1'b0;
      hcyc(4);
      tx_q.push_back(8'hC6);
      hcyc(6);
      r0 = rx_got.size();
      words[0] = 8'h5A;
      run_frame(0, words, 8, 1'b0, got, oe_ok, lat);
      chk("post_rst_rx", 32'(rx_data[0]), 32'h5A);
      chk("post_rst_rx_cnt", 32'(rx_got.size() - r0), 32'd1);
      chk("post_rst_miso", 32'(got[0]), 32'hC6);

      // Randomised frames: k queued words then default words, checked against word lists.
      for (int it = 0; it < 8; it++) begin
         m = $urandom_range(0, 3);
         n = $urandom_range(1, 3);
         k = $urandom_range(0, n);
         sel = m;
         for (int i = 0; i < 4; i++) begin
            words[i] = 8'($urandom);
            txw[i]   = 8'($urandom);
         end
         for (int i = 0; i < k; i++) tx_q.push_back(txw[i]);
         hcyc(6);
         r0 = rx_got.size(); u0 = und_cnt; a0 = ab_cnt;
         run_frame(m, words, 8 * n, 1'b0, got, oe_ok, lat);
         for (int i = 0; i < n; i++) begin
            exp_rx = words[i];
            chk($sformatf("rnd%0d_miso%0d", it, i), 32'(got[i]), (i < k) ? 32'(txw[i]) : 32'h00);
            chk($sformatf("rnd%0d_rx%0d", it, i),
                (rx_got.size() > r0 + i) ? 32'(rx_got[r0 + i]) : 32'hFFFF_FFFF, 32'(exp_rx));
         end
         chk($sformatf("rnd%0d_underrun", it), 32'(und_cnt - u0), 32'(n - k));
         chk($sformatf("rnd%0d_abort", it), 32'(ab_cnt - a0), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/azadi_spi_responder.md
Name: azadi_spi_responder

Overview:
- SPI responder (slave) that sits at the far end of the SoC's SPI host pins (ss_o, sclk_o, sd_o, sd_i).
- Used as an on-chip loopback target and as a device model for system tests.
- Oversamples the SPI pins in the system clock domain and exchanges DATA_W-bit words full-duplex.
- Exposes a one-entry TX holding register and an RX word strobe to local logic.

Parameters:
- DATA_W, 8: word length in bits (2..32).
- CPOL, 0: idle level of sclk.
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- DEFAULT_TX, 8'h00: word shifted out when the holding register is empty at a word start (width DATA_W).

Ports:
- clk_i  input  1  system clock; must be >= 4x sclk frequency.
- rst_i  input  1  asynchronous reset, active-high.
- sclk_i  input  1  SPI clock from host (asynchronous).
- ss_ni  input  1  slave select, active-low (asynchronous).
- mosi_i  input  1  host-to-responder serial data (asynchronous).
- miso_o  output  1  responder-to-host serial data.
- miso_oe_o  output  1  MISO drive enable; high only while selected.
- tx_data_i  input  DATA_W  word to send.
- tx_valid_i  input  1  tx_data_i offered.
- tx_ready_o  output  1  holding register empty.
- rx_data_o  output  DATA_W  last complete received word.
- rx_valid_o  output  1  one-cycle pulse when rx_data_o updates.
- tx_underrun_o  output  1  one-cycle pulse when DEFAULT_TX is used.
- abort_o  output  1  one-cycle pulse when ss_n rises mid-word.

Behaviour:
- Reset values: miso_o=0, miso_oe_o=0, tx_ready_o=1, rx_data_o=0, rx_valid_o=0, tx_underrun_o=0, abort_o=0. FSM=IDLE, bit_cnt=0, holding register empty.
- Synchronisation: sclk_i, ss_ni and mosi_i each pass through a 2-FF synchroniser (synchronisers reset to sclk=CPOL, ss_n=1, mosi=0). A third register on sclk provides edge detection.
- Pin-to-internal-event latency is 3 clk_i cycles.
- Edge decode: sample edge = sclk rising when CPOL==CPHA, otherwise falling. Shift edge = the opposite edge.
- Holding register: write when tx_valid_i && tx_ready_o. tx_ready_o falls the next cycle. It rises the cycle after the holding register is loaded into the shifter.
- Word load: loading the shifter consumes the holding register if full. If empty, the shifter gets DEFAULT_TX and tx_underrun_o pulses.
- Same-cycle load and write with an empty holding register: the load takes DEFAULT_TX; the write fills the holding register for the next word.
- FSM states:
  - IDLE: miso_oe_o=0, bit_cnt=0.
  - On synced ss_n falling → ACTIVE, miso_oe_o=1 the same cycle.
  - ACTIVE, CPHA=0: load the word on entry to ACTIVE, and on the shift edge that follows the DATA_W-th sample.
  - ACTIVE, CPHA=1: load the word on the first shift edge of each word.
  - ACTIVE, output: miso_o is always shifter MSB (MSB first). Other shift edges shift the shifter left by one.
  - ACTIVE, sample edge: rx shifter <= {rx_shift[DATA_W-2:0], mosi_sync}; bit_cnt++.
  - ACTIVE, word end: when bit_cnt reaches DATA_W, rx_data_o <= full word, rx_valid_o pulses for one cycle (same cycle as register update), bit_cnt wraps to 0.
  - ACTIVE, exit: synced ss_n rising → IDLE; miso_oe_o=0 and miso_o=0 the next cycle.
- Abort: if ss_n rises with bit_cnt != 0, abort_o pulses for one cycle. Partial RX bits are discarded (rx_data_o unchanged, no rx_valid_o). The loaded TX word is lost, not requeued.
- ss_n rising on the same cycle as a sample edge: the sample is taken first; if it completes the word, rx_valid_o pulses and no abort is flagged.
- Edge and ss_n falling on the same cycle: the ss_n falling is processed, the sclk edge is ignored.
- Reset mid-frame: all state returns to reset values immediately; the frame is not completed.
- Multi-word frames: back-to-back words within one ss_n low period are supported with no gap cycles.

Decomposition:
- Package azadi_spi_pkg holds:
  - the mode typedef (2-bit {CPOL,CPHA});
  - the FSM state enum (IDLE, ACTIVE);
  - the synchroniser reset-value constants.
- One sub-module: azadi_sync_2ff (parameterised reset value), instantiated three times.

Test Plan:
- Mode 0, DATA_W=8, tx_data 8'hA5 preloaded; host sends 8'h3C at sclk=clk/8 → MISO bits 1,0,1,0,0,1,0,1; rx_data_o=8'h3C with a single rx_valid_o pulse; tx_ready_o=1 after load.
- Empty holding register, host clocks 8'hFF → MISO=8'h00, tx_underrun_o one pulse at ss_n fall, rx_data_o=8'hFF.
- Three-word frame, host sends 8'h01,8'h02,8'h03 while bench refills 8'h11,8'h22,8'h33 → three rx_valid_o pulses in order; host receives 8'h11,8'h22,8'h33; no underrun.
- ss_n released after 5 bits of 8'hC3 → abort_o pulses once; rx_data_o retains previous value; miso_oe_o=0 within 4 cycles of the pin edge.
- Repeat scenario 1 for modes 1, 2, 3 → identical data results.
- Assert rst_i mid-word 4 → all outputs at reset values the same cycle; next full frame 8'h5A receives correctly.
